// File: rtl/aligner_pipe.sv
// rtl/aligner_pipe.sv - two-stage FMA addend aligner with valid/ready handshake, flush and tag sideband
module aligner_pipe #(
  parameter int C_EXP  = 8,
  parameter int C_MANT = 23,
  parameter int C_BIAS = 127,
  parameter int TAG_W  = 4,
  localparam int ALIGN_W = 3*C_MANT+5,
  localparam int SFT_OFS = C_MANT+4,
  localparam int EW      = C_EXP+2,
  localparam int MW      = C_MANT+1
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic               In_Valid_SI,
  output logic               In_Ready_SO,
  input  logic               Mode_SI,
  input  logic [C_EXP-1:0]   Exp_a_DI,
  input  logic [C_EXP-1:0]   Exp_b_DI,
  input  logic [C_EXP-1:0]   Exp_c_DI,
  input  logic [C_MANT:0]    Mant_a_DI,
  input  logic               Sign_a_DI,
  input  logic               Sign_b_DI,
  input  logic               Sign_c_DI,
  input  logic [TAG_W-1:0]   Tag_DI,
  input  logic               Flush_SI,
  output logic               Out_Valid_SO,
  input  logic               Out_Ready_SI,
  output logic [ALIGN_W:0]   Mant_postalig_DO,
  output logic [EW-1:0]      Exp_postalig_DO,
  output logic               Sign_postalig_DO,
  output logic               Sub_SO,
  output logic               Sign_amt_DO,
  output logic               Sft_stop_SO,
  output logic               Sticky_SO,
  output logic [TAG_W-1:0]   Tag_DO
);

  localparam logic [EW-1:0] BIAS_E  = EW'(C_BIAS);
  localparam logic [EW-1:0] OFS_E   = EW'(SFT_OFS);
  localparam logic [EW-1:0] ALIGN_E = EW'(ALIGN_W);

  // Stage 1 state
  logic              s1_valid_q;
  logic              s1_mode_q, s1_sub_q, s1_sign_amt_q, s1_stop_q;
  logic [EW-1:0]     s1_sft_amt_q, s1_exp_bc_q;
  logic [C_EXP-1:0]  s1_exp_a_q;
  logic [MW-1:0]     s1_mant_a_q;
  logic              s1_sign_a_q, s1_sign_bc_q;
  logic [TAG_W-1:0]  s1_tag_q;

  // Stage 2 state (drives the outputs directly)
  logic              s2_valid_q;
  logic [ALIGN_W:0]  s2_mant_q, s2_mant_d;
  logic [EW-1:0]     s2_exp_q, s2_exp_d;
  logic              s2_sign_q, s2_sign_d;
  logic              s2_sticky_q, s2_sticky_d;
  logic              s2_sub_q, s2_sign_amt_q, s2_stop_q;
  logic [TAG_W-1:0]  s2_tag_q;

  // Handshake: a stage loads when empty or when its content moves on
  logic s2_load, s1_fwd, in_fire;
  assign s2_load     = ~s2_valid_q | Out_Ready_SI;
  assign In_Ready_SO = ~s1_valid_q | s2_load;
  assign in_fire     = In_Valid_SI & In_Ready_SO;
  assign s1_fwd      = s1_valid_q & s2_load;

  // Stage 1 exponent arithmetic, all modulo 2^EW so the MSB carries the sign
  logic [EW-1:0] sum_bc, s1_sft_amt_d, s1_exp_bc_d;
  logic          sign_raw;
  assign sum_bc       = EW'(Exp_b_DI) + EW'(Exp_c_DI);
  assign s1_sft_amt_d = sum_bc - EW'(Exp_a_DI) - BIAS_E + OFS_E;
  assign s1_exp_bc_d  = sum_bc - BIAS_E + OFS_E;
  assign sign_raw     = s1_sft_amt_d[EW-1];

  // Stage 2 shifter: addend placed above ALIGN_W zeros, low MW bits fall out into sticky
  logic [ALIGN_W+MW-1:0] shifted;
  logic [ALIGN_W-1:0]    aligned;
  logic [MW-1:0]         shifted_out;
  assign shifted     = {s1_mant_a_q, {ALIGN_W{1'b0}}} >> s1_sft_amt_q;
  assign aligned     = shifted[ALIGN_W+MW-1:MW];
  assign shifted_out = shifted[MW-1:0];

  // Stage 2 result selection: MUL-only, addend dominates, shifted past range, or normal align
  always_comb begin
    s2_mant_d   = '0;
    s2_sticky_d = 1'b0;
    s2_exp_d    = s1_exp_bc_q;
    s2_sign_d   = s1_sign_bc_q;
    if (s1_mode_q) begin
      s2_mant_d = '0;
    end else if (s1_sign_amt_q) begin
      s2_mant_d = {1'b0, s1_mant_a_q, {(2*C_MANT+4){1'b0}}};
      s2_exp_d  = {2'b00, s1_exp_a_q};
      s2_sign_d = s1_sign_a_q;
    end else if (s1_stop_q) begin
      s2_sticky_d = |s1_mant_a_q;
    end else begin
      s2_mant_d   = s1_sub_q ? {1'b1, ~aligned} : {1'b0, aligned};
      s2_sticky_d = |shifted_out;
    end
  end

  // Stage 1 register: valid follows the input handshake, flush wins over accept
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_valid_q    <= 1'b0;
      s1_mode_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_sign_amt_q <= 1'b0;
      s1_stop_q     <= 1'b0;
      s1_sft_amt_q  <= '0;
      s1_exp_bc_q   <= '0;
      s1_exp_a_q    <= '0;
      s1_mant_a_q   <= '0;
      s1_sign_a_q   <= 1'b0;
      s1_sign_bc_q  <= 1'b0;
      s1_tag_q      <= '0;
    end else begin
      if (Flush_SI)         s1_valid_q <= 1'b0;
      else if (In_Ready_SO) s1_valid_q <= In_Valid_SI;
      if (in_fire) begin
        s1_mode_q     <= Mode_SI;
        s1_sub_q      <= ~Mode_SI & (Sign_a_DI ^ Sign_b_DI ^ Sign_c_DI);
        s1_sign_amt_q <= ~Mode_SI & sign_raw;
        s1_stop_q     <= ~Mode_SI & ~sign_raw & (s1_sft_amt_d >= ALIGN_E);
        s1_sft_amt_q  <= s1_sft_amt_d;
        s1_exp_bc_q   <= s1_exp_bc_d;
        s1_exp_a_q    <= Exp_a_DI;
        s1_mant_a_q   <= Mant_a_DI;
        s1_sign_a_q   <= Sign_a_DI;
        s1_sign_bc_q  <= Sign_b_DI ^ Sign_c_DI;
        s1_tag_q      <= Tag_DI;
      end
    end
  end

  // Stage 2 register: holds its data while the output is stalled
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s2_valid_q    <= 1'b0;
      s2_mant_q     <= '0;
      s2_exp_q      <= '0;
      s2_sign_q     <= 1'b0;
      s2_sticky_q   <= 1'b0;
      s2_sub_q      <= 1'b0;
      s2_sign_amt_q <= 1'b0;
      s2_stop_q     <= 1'b0;
      s2_tag_q      <= '0;
    end else begin
      if (Flush_SI)     s2_valid_q <= 1'b0;
      else if (s2_load) s2_valid_q <= s1_valid_q;
      if (s1_fwd) begin
        s2_mant_q     <= s2_mant_d;
        s2_exp_q      <= s2_exp_d;
        s2_sign_q     <= s2_sign_d;
        s2_sticky_q   <= s2_sticky_d;
        s2_sub_q      <= s1_sub_q;
        s2_sign_amt_q <= s1_sign_amt_q;
        s2_stop_q     <= s1_stop_q;
        s2_tag_q      <= s1_tag_q;
      end
    end
  end

  assign Out_Valid_SO     = s2_valid_q;
  assign Mant_postalig_DO = s2_mant_q;
  assign Exp_postalig_DO  = s2_exp_q;
  assign Sign_postalig_DO = s2_sign_q;
  assign Sub_SO           = s2_sub_q;
  assign Sign_amt_DO      = s2_sign_amt_q;
  assign Sft_stop_SO      = s2_stop_q;
  assign Sticky_SO        = s2_sticky_q;
  assign Tag_DO           = s2_tag_q;

endmodule

// File: tb/tb_aligner_pipe.sv
// tb/tb_aligner_pipe.sv - scoreboard bench for aligner_pipe
module tb_aligner_pipe;

  typedef struct packed {
    logic [74:0] mant;
    logic [9:0]  exp;
    logic        sign;
    logic        sub;
    logic        sign_amt;
    logic        stop;
    logic        sticky;
    logic [3:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, mode = 1'b0;
  logic [7:0]  ea = '0, eb = '0, ec = '0;
  logic [23:0] ma = '0;
  logic        sa = 1'b0, sb = 1'b0, sc = 1'b0;
  logic [3:0]  tag = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [74:0] mant_o;
  logic [9:0]  exp_o;
  logic        sign_o, sub_o, sign_amt_o, stop_o, sticky_o;
  logic [3:0]  tag_o;

  int   n_checks = 0;
  int   n_fail = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  aligner_pipe dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .In_Valid_SI(in_valid), .In_Ready_SO(in_ready), .Mode_SI(mode),
    .Exp_a_DI(ea), .Exp_b_DI(eb), .Exp_c_DI(ec), .Mant_a_DI(ma),
    .Sign_a_DI(sa), .Sign_b_DI(sb), .Sign_c_DI(sc), .Tag_DI(tag),
    .Flush_SI(flush), .Out_Valid_SO(out_valid), .Out_Ready_SI(out_ready),
    .Mant_postalig_DO(mant_o), .Exp_postalig_DO(exp_o), .Sign_postalig_DO(sign_o),
    .Sub_SO(sub_o), .Sign_amt_DO(sign_amt_o), .Sft_stop_SO(stop_o),
    .Sticky_SO(sticky_o), .Tag_DO(tag_o)
  );

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: bit-by-bit placement of each addend bit after the shift
  function automatic res_t model(input int a, input int b, input int c, input logic [23:0] m,
                                 input logic s_a, input logic s_b, input logic s_c,
                                 input logic md, input logic [3:0] t);
    res_t r;
    int sft, pos;
    logic [73:0] al;
    r = '0;
    r.tag = t;
    sft = b + c - a - 127 + 27;
    r.exp = 10'(b + c - 127 + 27);
    r.sign = s_b ^ s_c;
    if (md) return r;
    r.sub = s_a ^ s_b ^ s_c;
    if (sft < 0) begin
      r.sign_amt = 1'b1;
      r.mant = 75'(m) << 50;
      r.exp = 10'(a);
      r.sign = s_a;
    end else if (sft >= 74) begin
      r.stop = 1'b1;
      r.sticky = (m != 0);
    end else begin
      al = '0;
      for (int i = 0; i < 24; i++) begin
        pos = i + 74 - sft;
        if (m[i]) begin
          if (pos >= 24) al[pos-24] = 1'b1;
          else r.sticky = 1'b1;
        end
      end
      r.mant = r.sub ? {1'b1, ~al} : {1'b0, al};
    end
    return r;
  endfunction

  task automatic drive(input int a, input int b, input int c, input logic [23:0] m,
                       input logic s_a, input logic s_b, input logic s_c,
                       input logic md, input logic [3:0] t);
    ea = 8'(a); eb = 8'(b); ec = 8'(c); ma = m;
    sa = s_a; sb = s_b; sc = s_c; mode = md; tag = t;
  endtask

  // Present the currently driven op until accepted, pushing its expected result on accept
  task automatic send(input res_t e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input int a, input int b, input int c, input logic [23:0] m,
                            input logic s_a, input logic s_b, input logic s_c,
                            input logic md, input logic [3:0] t);
    drive(a, b, c, m, s_a, s_b, s_c, md, t);
    send(model(a, b, c, m, s_a, s_b, s_c, md, t));
  endtask

  // Output monitor: every valid cycle must match the head of the scoreboard (also covers stall stability)
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          e = sb_q[0];
          check_eq("mant", mant_o, e.mant);
          check_eq("exp", exp_o, e.exp);
          check_eq("sign", sign_o, e.sign);
          check_eq("sub", sub_o, e.sub);
          check_eq("sign_amt", sign_amt_o, e.sign_amt);
          check_eq("sft_stop", stop_o, e.stop);
          check_eq("sticky", sticky_o, e.sticky);
          check_eq("tag", tag_o, e.tag);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    res_t e;
    logic done;
    logic [31:0] rv;
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_mant", mant_o, 0);
    check_eq("rst_exp", exp_o, 0);
    check_eq("rst_tag", tag_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unity product, aligned addend lands at bit 46; also checks 2-cycle latency
    drive(127, 127, 127, 24'h800000, 0, 0, 0, 0, 4'h1);
    e = '0; e.mant = 75'(1) << 46; e.exp = 10'd154; e.tag = 4'h1;
    send(e);
    check_eq("lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    check_eq("lat_two", out_valid, 1);
    drain();

    // Addend exponent dominates: no shift, no inversion
    drive(200, 127, 127, 24'h800000, 1, 0, 0, 0, 4'h2);
    e = '0; e.mant = {1'b0, 24'h800000, 50'h0}; e.exp = 10'd200; e.sign = 1'b1;
    e.sub = 1'b1; e.sign_amt = 1'b1; e.tag = 4'h2;
    send(e);
    // Shift of 70 with subtraction and sticky
    drive(127, 127, 170, 24'h800001, 1, 0, 0, 0, 4'h3);
    e = '0; e.mant = {1'b1, ~74'h8}; e.exp = 10'd197; e.sub = 1'b1; e.sticky = 1'b1; e.tag = 4'h3;
    send(e);
    // Shift beyond range
    drive(1, 127, 127, 24'h800000, 0, 0, 0, 0, 4'h4);
    e = '0; e.exp = 10'd154; e.stop = 1'b1; e.sticky = 1'b1; e.tag = 4'h4;
    send(e);
    // Same operands in MUL-only mode
    drive(1, 127, 127, 24'h800000, 0, 0, 0, 1, 4'h5);
    e = '0; e.exp = 10'd154; e.tag = 4'h5;
    send(e);
    drain();

    // Stall: two accepts fill the pipe, third waits until output ready returns
    out_ready = 1'b0;
    send_model(130, 120, 140, 24'hA5A5A5, 0, 1, 0, 0, 4'h6);
    send_model(100, 127, 127, 24'hFFFFFF, 0, 0, 1, 0, 4'h7);
    check_eq("stall_in_ready", in_ready, 0);
    fork
      send_model(127, 127, 127, 24'hC00001, 1, 1, 1, 0, 4'h8);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush mid-stall discards both in-flight ops
    out_ready = 1'b0;
    send_model(127, 127, 127, 24'h812345, 0, 0, 0, 0, 4'h9);
    send_model(127, 127, 128, 24'h900000, 0, 0, 0, 0, 4'hA);
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    check_eq("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Flush on an empty pipe beats a simultaneous accept
    #1;
    drive(127, 127, 127, 24'h800000, 0, 0, 0, 0, 4'hB);
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("flush_prio_valid", out_valid, 0);
    end

    // Reset mid-stall discards everything immediately
    out_ready = 1'b0;
    send_model(127, 127, 127, 24'h800000, 0, 0, 0, 0, 4'hC);
    send_model(127, 127, 127, 24'h800000, 0, 0, 0, 0, 4'hD);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_ready", in_ready, 1);
    check_eq("rst_mid_mant", mant_o, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_valid", out_valid, 0);

    // Random traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [23:0] m;
          int a, b, c;
          rv = $urandom;
          m = {1'b1, rv[22:0]};
          a = $urandom_range(0, 255);
          b = $urandom_range(60, 200);
          c = $urandom_range(60, 200);
          rv = $urandom;
          send_model(a, b, c, m, rv[0], rv[1], rv[2], (rv[5:3] == 3'd0), 4'(k));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
